// File: rtl/ring_sweep_ctrl.sv
// Ring-oscillator frequency sweep controller: selects a ring tap, waits for it to
// settle, counts synchronized ring edges over a programmable window and reports per tap.
module ring_sweep_ctrl #(
   parameter int unsigned COUNT_W = 16,
   parameter int unsigned SETTLE  = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               sweep,
   input  logic [2:0]         tap_sel,
   input  logic [1:0]         win_sel,
   input  logic               ring_in,
   output logic [2:0]         tap_out,
   output logic               busy,
   output logic               res_valid,
   input  logic               res_ready,
   output logic [2:0]         res_tap,
   output logic [COUNT_W-1:0] res_count,
   output logic               res_ovf,
   output logic               done
);

   localparam int unsigned TMR_W = 12;
   localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE - 1);

   typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_MEASURE, S_REPORT} state_t;

   state_t             state_q;
   logic               sync1_q, sync2_q, hist_q;
   logic               sweep_q;
   logic [1:0]         win_q;
   logic [2:0]         tap_q;
   logic [TMR_W-1:0]   tmr_q;
   logic [COUNT_W-1:0] cnt_q, cnt_d;
   logic               ovf_q, ovf_d;
   logic               busy_q, res_valid_q, res_ovf_q, done_q;
   logic [2:0]         res_tap_q;
   logic [COUNT_W-1:0] res_count_q;
   logic               edge_c;
   logic [TMR_W-1:0]   win_last_c;

   // Two-flop synchronizer plus history flop for rising-edge detection
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         hist_q  <= 1'b0;
      end else begin
         sync1_q <= ring_in;
         sync2_q <= sync1_q;
         hist_q  <= sync2_q;
      end
   end

   // Saturating edge counter next value; overflow flags a saturating or post-saturation edge
   always_comb begin
      edge_c     = sync2_q & ~hist_q;
      win_last_c = TMR_W'((TMR_W'(256) << win_q) - TMR_W'(1));
      cnt_d      = cnt_q;
      ovf_d      = ovf_q;
      if (edge_c) begin
         if (!(&cnt_q)) cnt_d = cnt_q + COUNT_W'(1);
         if (&cnt_q[COUNT_W-1:1]) ovf_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         sweep_q     <= 1'b0;
         win_q       <= 2'd0;
         tap_q       <= 3'd0;
         tmr_q       <= '0;
         cnt_q       <= '0;
         ovf_q       <= 1'b0;
         busy_q      <= 1'b0;
         res_valid_q <= 1'b0;
         res_tap_q   <= 3'd0;
         res_count_q <= '0;
         res_ovf_q   <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  sweep_q <= sweep;
                  win_q   <= win_sel;
                  tap_q   <= tap_sel;
                  tmr_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= S_SETTLE;
               end
            end
            S_SETTLE: begin
               if (tmr_q == SETTLE_LAST) begin
                  tmr_q   <= '0;
                  cnt_q   <= '0;
                  ovf_q   <= 1'b0;
                  state_q <= S_MEASURE;
               end else begin
                  tmr_q <= tmr_q + TMR_W'(1);
               end
            end
            S_MEASURE: begin
               cnt_q <= cnt_d;
               ovf_q <= ovf_d;
               if (tmr_q == win_last_c) begin
                  res_valid_q <= 1'b1;
                  res_tap_q   <= tap_q;
                  res_count_q <= cnt_d;
                  res_ovf_q   <= ovf_d;
                  state_q     <= S_REPORT;
               end else begin
                  tmr_q <= tmr_q + TMR_W'(1);
               end
            end
            S_REPORT: begin
               if (res_ready) begin
                  res_valid_q <= 1'b0;
                  tmr_q       <= '0;
                  if (sweep_q && (tap_q != 3'd7)) begin
                     tap_q   <= tap_q + 3'd1;
                     state_q <= S_SETTLE;
                  end else begin
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     state_q <= S_IDLE;
                  end
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign tap_out   = tap_q;
   assign busy      = busy_q;
   assign res_valid = res_valid_q;
   assign res_tap   = res_tap_q;
   assign res_count = res_count_q;
   assign res_ovf   = res_ovf_q;
   assign done      = done_q;

endmodule

// File: tb/tb_ring_sweep_ctrl.sv
// Scoreboard bench for ring_sweep_ctrl: expected taps are queued at start, and each result
// is checked against edge counts recomputed from the recorded ring_in history.
module tb_ring_sweep_ctrl;

   localparam int unsigned CW = 8;
   localparam int SET    = 16;
   localparam int MAXC   = 255;
   localparam int MAXCYC = 131072;

   logic          clk = 1'b0;
   logic          rst, start, sweep, ring_in, res_ready;
   logic [2:0]    tap_sel;
   logic [1:0]    win_sel;
   logic [2:0]    tap_out, res_tap;
   logic          busy, res_valid, res_ovf, done;
   logic [CW-1:0] res_count;

   typedef struct {
      int tap;
      int win;
      bit first;
      bit last;
      int t0;
   } item_t;

   item_t exp_q[$];
   int    checks = 0;
   int    errors = 0;
   int    cyc = 0;
   bit    rhist[MAXCYC];
   bit    mon_en = 1'b0;
   int    ring_mode = 0;
   int    ring_period = 8;
   int    ready_mode = 0;

   ring_sweep_ctrl #(.COUNT_W(CW), .SETTLE(SET)) dut (
      .clk(clk), .rst(rst), .start(start), .sweep(sweep), .tap_sel(tap_sel),
      .win_sel(win_sel), .ring_in(ring_in), .tap_out(tap_out), .busy(busy),
      .res_valid(res_valid), .res_ready(res_ready), .res_tap(res_tap),
      .res_count(res_count), .res_ovf(res_ovf), .done(done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Ring oscillator stand-in: square wave of chosen period, or random bits
   initial begin
      int ph;
      ph = 0;
      ring_in = 1'b0;
      forever begin
         @(negedge clk);
         ph++;
         if (ring_mode == 0) ring_in = ((ph % ring_period) < (ring_period / 2));
         else                ring_in = 1'($urandom_range(0, 1));
      end
   end

   // Consumer: always ready, randomly ready, or stalled
   initial begin
      res_ready = 1'b1;
      forever begin
         @(negedge clk);
         case (ready_mode)
            0:       res_ready = 1'b1;
            1:       res_ready = 1'($urandom_range(0, 1));
            default: res_ready = 1'b0;
         endcase
      end
   end

   // Monitor: records ring history, checks results, handshakes and done pulses
   initial begin
      bit            prev_valid, have_cur;
      item_t         cur;
      int            last_hs, exp_done, t0, cnt;
      logic [2:0]    cap_tap;
      logic [CW-1:0] cap_cnt;
      logic          cap_ovf;
      prev_valid = 1'b0;
      have_cur   = 1'b0;
      last_hs    = 0;
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         if (cyc < MAXCYC) rhist[cyc] = ring_in;
         if (!mon_en) begin
            prev_valid = 1'b0;
            have_cur   = 1'b0;
         end else begin
            exp_done = 0;
            if (prev_valid && res_ready && have_cur) begin
               last_hs = cyc;
               chk("valid_drop", int'(res_valid), 0);
               if (cur.last) begin
                  exp_done = 1;
                  chk("busy_idle", int'(busy), 0);
               end
               have_cur = 1'b0;
            end
            chk("done", int'(done), exp_done);
            if (res_valid && !prev_valid) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_result: got tap %0d expected no result (cycle %0d)", res_tap, cyc);
               end else begin
                  cur      = exp_q.pop_front();
                  have_cur = 1'b1;
                  t0       = cur.first ? cur.t0 : last_hs;
                  cnt      = 0;
                  for (int k = t0 + SET - 1; k <= t0 + SET + cur.win - 2; k++)
                     if (rhist[k] && !rhist[k-1]) cnt++;
                  chk("latency", cyc, t0 + SET + cur.win);
                  chk("res_tap", int'(res_tap), cur.tap);
                  chk("res_count", int'(res_count), (cnt > MAXC) ? MAXC : cnt);
                  chk("res_ovf", int'(res_ovf), (cnt >= MAXC) ? 1 : 0);
                  cap_tap = res_tap;
                  cap_cnt = res_count;
                  cap_ovf = res_ovf;
               end
            end else if (res_valid && have_cur) begin
               chk("hold_tap", int'(res_tap), int'(cap_tap));
               chk("hold_count", int'(res_count), int'(cap_cnt));
               chk("hold_ovf", int'(res_ovf), int'(cap_ovf));
               chk("hold_tap_out", int'(tap_out), cur.tap);
            end
            prev_valid = res_valid;
         end
      end
   end

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_tap_out"}, int'(tap_out), 0);
      chk({tag, "_busy"}, int'(busy), 0);
      chk({tag, "_res_valid"}, int'(res_valid), 0);
      chk({tag, "_res_tap"}, int'(res_tap), 0);
      chk({tag, "_res_count"}, int'(res_count), 0);
      chk({tag, "_res_ovf"}, int'(res_ovf), 0);
      chk({tag, "_done"}, int'(done), 0);
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while (!(busy == 1'b0 && exp_q.size() == 0) && n < 20000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 20000) chk("run_timeout", 1, 0);
   endtask

   task automatic issue(input bit sw, input int tap, input int ws);
      int n;
      @(negedge clk);
      n = sw ? (8 - tap) : 1;
      for (int i = 0; i < n; i++) begin
         item_t it;
         it.tap   = tap + i;
         it.win   = 256 << ws;
         it.first = (i == 0);
         it.last  = (i == n - 1);
         it.t0    = cyc + 1;
         exp_q.push_back(it);
      end
      start   = 1'b1;
      sweep   = sw;
      tap_sel = 3'(tap);
      win_sel = 2'(ws);
      @(negedge clk);
      start   = 1'b0;
      sweep   = 1'($urandom);
      tap_sel = 3'($urandom);
      win_sel = 2'($urandom);
      chk("busy_start", int'(busy), 1);
      chk("tap_out_start", int'(tap_out), tap);
   endtask

   task automatic run(input bit sw, input int tap, input int ws);
      wait_done();
      issue(sw, tap, ws);
      wait_done();
   endtask

   initial begin
      int target, n;
      bit sw;
      rst = 1'b1; start = 1'b0; sweep = 1'b0; tap_sel = 3'd0; win_sel = 2'd0;
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      rst = 1'b0;
      mon_en = 1'b1;

      // Single tap 3, square wave period 8
      ring_mode = 0; ring_period = 8; ready_mode = 0;
      run(1'b0, 3, 0);

      // Sweep from tap 5 through 7
      run(1'b1, 5, 0);

      // Saturation: period 4 over a 2048-cycle window
      ring_period = 4;
      run(1'b0, 2, 3);

      // Single-measurement sweep from tap 7
      ring_period = 6;
      run(1'b1, 7, 1);

      // Stalled consumer with an ignored start pulse
      ring_mode = 1; ready_mode = 2;
      issue(1'b1, 6, 0);
      n = 0;
      while (!res_valid && n < 3000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 3000) chk("valid_timeout", 1, 0);
      repeat (20) @(negedge clk);
      start = 1'b1; sweep = 1'b1; tap_sel = 3'd1; win_sel = 2'd3;
      @(negedge clk);
      start = 1'b0;
      repeat (29) @(negedge clk);
      ready_mode = 0;
      wait_done();

      // Reset 100 cycles into MEASURE
      ring_mode = 0; ring_period = 10;
      issue(1'b0, 4, 2);
      target = exp_q[0].t0 + SET + 100;
      while (cyc < target) @(negedge clk);
      mon_en = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      #2;
      check_reset_outputs("midrun_reset");
      @(negedge clk);
      rst = 1'b0;
      exp_q.delete();
      mon_en = 1'b1;
      run(1'b0, 6, 1);

      // Randomized runs
      for (int r = 0; r < 10; r++) begin
         sw          = ($urandom_range(0, 3) == 0);
         ring_mode   = int'($urandom_range(0, 1));
         ring_period = 2 * int'($urandom_range(1, 10));
         ready_mode  = int'($urandom_range(0, 1));
         run(sw, int'($urandom_range(0, 7)), sw ? 0 : int'($urandom_range(0, 3)));
      end

      repeat (5) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ring_sweep_ctrl.md
RING_SWEEP_CTRL -- requirements
Module: ring_sweep_ctrl

Interface
REQ-001 Parameter: COUNT_W, default 16, edge-counter and result width (8..24).
REQ-002 Parameter: SETTLE, default 16, clk cycles waited after a tap change before counting (1..255).
REQ-003 Port: clk  in  1  system clock; the only clock in the block.
REQ-004 Port: rst  in  1  synchronous, active-high reset.
REQ-005 Port: start  in  1  one-cycle request to begin a measurement run; ignored while busy=1.
REQ-006 Port: sweep  in  1  sampled at accepted start; 1 = measure taps tap_sel..7 in order, 0 = measure tap_sel only.
REQ-007 Port: tap_sel  in  3  first (or only) tap, sampled at accepted start.
REQ-008 Port: win_sel  in  2  sampled at accepted start; window WIN = 256 << win_sel cycles (256/512/1024/2048).
REQ-009 Port: ring_in  in  1  asynchronous ring-oscillator output.
REQ-010 Port: tap_out  out  3  tap select driven to the tapped ring.
REQ-011 Port: busy  out  1  high in every state except IDLE.
REQ-012 Port: res_valid  out  1  result available.
REQ-013 Port: res_ready  in  1  consumer accepts result when res_valid & res_ready.
REQ-014 Port: res_tap  out  3  tap the result belongs to.
REQ-015 Port: res_count  out  COUNT_W  rising edges of ring_in counted in the window.
REQ-016 Port: res_ovf  out  1  counter saturated during the window.
REQ-017 Port: done  out  1  one-cycle pulse when a run completes.

Function
REQ-018 ring_in SHALL pass through a 2-flop synchronizer plus one history flop; a rising edge is detected when sync2=1 and hist=0.
REQ-019 The FSM SHALL have the states IDLE, SETTLE, MEASURE and REPORT.
REQ-020 IDLE: start=1 latches sweep, win_sel and tap_sel into tap_out, then moves to SETTLE next cycle.
REQ-021 SETTLE: the block SHALL stay in SETTLE for exactly SETTLE cycles, then move to MEASURE; no edges are counted.
REQ-022 MEASURE: the counter SHALL clear on entry, increment on each detected edge during exactly WIN cycles, then move to REPORT.
REQ-023 The counter SHALL saturate at 2^COUNT_W-1, and res_ovf SHALL set if an edge arrives while the counter is saturated or the counter reaches saturation.
REQ-024 Entering REPORT, the block SHALL assert res_valid and load res_tap=tap_out, res_count and res_ovf; these SHALL hold stable until the handshake completes.
REQ-025 REPORT with res_ready=1 (same cycle allowed) SHALL deassert res_valid next cycle; if sweep=1 and tap_out!=7, tap_out increments and the FSM goes to SETTLE; otherwise the FSM goes to IDLE and done pulses for one cycle.
REQ-026 Latency from an accepted start to res_valid SHALL be 1+SETTLE+WIN cycles.
REQ-027 Per-tap cycle with res_ready held high SHALL be SETTLE+WIN+1 cycles.
REQ-028 tap_out SHALL change only on start acceptance or on a REPORT handshake, never during MEASURE.
REQ-029 start, sweep, tap_sel and win_sel SHALL be ignored while busy=1.
REQ-030 sweep=1 with tap_sel=7 SHALL perform exactly one measurement.

Reset
REQ-031 rst=1 at a clock edge SHALL force IDLE, tap_out=0, busy=0, res_valid=0, res_tap=0, res_count=0, res_ovf=0, done=0, and clear the synchronizer, history and counter flops.
REQ-032 rst SHALL take effect from any state, including mid-MEASURE and mid-REPORT, and discard any partial result with no done pulse.

Verification
REQ-033 Single mode, tap_sel=3, win_sel=0, ring_in square wave period 8 clk, res_ready=1 -> res_valid at cycle 1+16+256 after start; res_tap=3; res_count=32±1; res_ovf=0; done pulses one cycle after the handshake.
REQ-034 Sweep mode, tap_sel=5, res_ready=1 -> three results with res_tap=5,6,7 in that order; done pulses once after the third result; busy falls with done.
REQ-035 COUNT_W=8, win_sel=3, ring_in period 4 clk -> res_count=255, res_ovf=1.
REQ-036 res_ready held 0 for 50 cycles in REPORT -> res_valid, res_tap and res_count stay stable; tap_out does not change; a start pulse in this period is ignored.
REQ-037 rst asserted 100 cycles into MEASURE -> next cycle all outputs take their reset values; a new start afterwards produces a correct result.
